// File: rtl/in_demux_bp.sv
// in_demux_bp: flow-controlled switch input demultiplexer.
// Packs each accepted operation and routes it into a one-deep registered slot
// per switch channel. A slot holds its operation until the downstream FIFO
// takes it, and upstream is told via a combinational ready. Operations with
// an out-of-range select are dropped, flagged for one cycle and counted.
module in_demux_bp #(
  parameter int NUM_SW_INST = 5,
  parameter int SEL_WIDTH   = 3,
  parameter int ADDR_WIDTH  = 5,
  parameter int W_WIDTH     = 8,
  parameter int ID_WIDTH    = 8,
  parameter int OP_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  output logic                   ready,
  input  logic [SEL_WIDTH-1:0]   sw_sel,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic                   wr_rd_op,
  input  logic [W_WIDTH-1:0]     wr_data,
  input  logic [ID_WIDTH-1:0]    op_id,
  input  logic [NUM_SW_INST-1:0] fifo_full,
  output logic [OP_WIDTH-1:0]    op_out [NUM_SW_INST],
  output logic [NUM_SW_INST-1:0] wr_fifo,
  output logic                   sel_err,
  output logic [7:0]             drop_cnt
);

  localparam int PK_W = ADDR_WIDTH + 1 + W_WIDTH + ID_WIDTH;

  logic [OP_WIDTH-1:0]    packed_op;
  logic [NUM_SW_INST-1:0] sel_hit;    // one-hot decode of sw_sel (all zero if illegal)
  logic [NUM_SW_INST-1:0] slot_free;  // slot empty or draining this edge
  logic [NUM_SW_INST-1:0] drain;      // slot content transfers to its FIFO this edge
  logic [NUM_SW_INST-1:0] load;       // slot receives the accepted operation this edge
  logic                   legal;
  logic                   accept;
  logic                   drop;

  // Pack the operation fields with op_id in the LSBs, zero-filling the top.
  always_comb begin
    packed_op = '0;
    packed_op[PK_W-1:0] = {addr, wr_rd_op, wr_data, op_id};
  end

  // Channel decode, per-slot drain/free status and upstream handshake.
  always_comb begin
    sel_hit   = '0;
    slot_free = '0;
    drain     = '0;
    for (int unsigned i = 0; i < NUM_SW_INST; i++) begin
      sel_hit[i]   = (sw_sel == SEL_WIDTH'(i));
      drain[i]     = wr_fifo[i] & ~fifo_full[i];
      slot_free[i] = ~wr_fifo[i] | ~fifo_full[i];
    end
    legal  = |sel_hit;
    // Illegal selects are always accepted so they can be dropped immediately.
    ready  = legal ? |(sel_hit & slot_free) : 1'b1;
    accept = valid & ready;
    load   = accept ? sel_hit : '0;
    drop   = accept & ~legal;
  end

  for (genvar g = 0; g < NUM_SW_INST; g++) begin : g_slot
    // Slot g: a load overrides a simultaneous drain, so a draining slot can
    // be refilled on the same edge without losing or duplicating anything.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        op_out[g]  <= '0;
        wr_fifo[g] <= 1'b0;
      end else if (load[g]) begin
        op_out[g]  <= packed_op;
        wr_fifo[g] <= 1'b1;
      end else if (drain[g]) begin
        op_out[g]  <= '0;
        wr_fifo[g] <= 1'b0;
      end
    end
  end

  // Drop flag pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_err <= drop;
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
